timer_event_ctrl: RTL and testbench

- Downstream consumer of the 20-bit gray/binary cascade timer and its wakeup pulse.
- Decodes the raw count to plain binary and detects alarm matches against a programmable compare value.
- Counts wakeup and alarm events and presents them to the host through a level IRQ with an ack handshake.
- Also provides an on-demand binary snapshot of the count.

---
 rtl/timer_event_ctrl.sv | 140 ++++++++++++++
 tb/tb_timer_event_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_event_ctrl.sv
// Consumer of the gray/binary cascade timer: decodes the count, detects alarm
// matches and wakeup edges, and reports counted events through a level IRQ.
module timer_event_ctrl #(
    parameter int unsigned CW = 20,
    parameter int unsigned GN = 3,
    parameter int unsigned EW = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [CW-1:0] cnt_in,
    input  logic          wakeup_in,
    input  logic [CW-1:0] cmp_val,
    input  logic          cmp_en,
    input  logic          snap_req,
    input  logic          irq_ack,
    output logic [CW-1:0] cnt_bin,
    output logic [CW-1:0] cnt_snap,
    output logic          snap_vld,
    output logic          irq,
    output logic [EW-1:0] evt_cnt,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, PEND, ACKW} state_t;

    localparam logic [EW:0] EVT_MAX = {1'b0, {EW{1'b1}}};

    state_t        state;
    logic          wake_q;
    logic          snap_q;
    logic          match_q;
    logic          pend_f;
    logic [CW-1:0] dec;
    logic          match;
    logic          wk_evt;
    logic          cmp_evt;
    logic          snap_evt;
    logic          has_evt;
    logic          ack_acc;
    logic [1:0]    inc;
    logic [EW:0]   sum;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    always_comb begin
        dec = cnt_in;
        for (int unsigned n = 0; n < GN; n++)
            dec[4*n +: 4] = gray2bin(cnt_in[4*n +: 4]);
    end

    assign match    = cmp_en & (cnt_bin == cmp_val);
    assign wk_evt   = wakeup_in & ~wake_q;
    assign cmp_evt  = match & ~match_q;
    assign snap_evt = snap_req & ~snap_q;
    assign inc      = {1'b0, wk_evt} + {1'b0, cmp_evt};
    assign has_evt  = wk_evt | cmp_evt;
    assign ack_acc  = (state == PEND) & irq_ack;
    assign sum      = {1'b0, evt_cnt} + {{(EW-1){1'b0}}, inc};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_bin  <= '0;
            cnt_snap <= '0;
            snap_vld <= 1'b0;
            wake_q   <= 1'b0;
            snap_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            cnt_bin  <= dec;
            wake_q   <= wakeup_in;
            snap_q   <= snap_req;
            match_q  <= match;
            snap_vld <= snap_evt;
            if (snap_evt)
                cnt_snap <= cnt_bin;
        end
    end

    // Events arriving in the ack cycle seed the fresh count instead of being dropped.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            evt_cnt <= '0;
            ovf     <= 1'b0;
        end else if (ack_acc) begin
            evt_cnt <= {{(EW-2){1'b0}}, inc};
            ovf     <= 1'b0;
        end else if (sum > EVT_MAX) begin
            evt_cnt <= '1;
            ovf     <= 1'b1;
        end else begin
            evt_cnt <= sum[EW-1:0];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            irq    <= 1'b0;
            pend_f <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    irq <= 1'b0;
                    if (has_evt || pend_f) begin
                        state  <= PEND;
                        irq    <= 1'b1;
                        pend_f <= 1'b0;
                    end
                end
                PEND: begin
                    irq <= 1'b1;
                    if (irq_ack) begin
                        state  <= ACKW;
                        irq    <= 1'b0;
                        pend_f <= has_evt;
                    end
                end
                ACKW: begin
                    irq <= 1'b0;
                    if (has_evt)
                        pend_f <= 1'b1;
                    if (!irq_ack)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_event_ctrl.sv
// Bench for timer_event_ctrl: decode table, hand-written handshake sequences,
// then randomized traffic against a behavioural model.
module tb_timer_event_ctrl;

    localparam int CW = 20;
    localparam int GN = 3;
    localparam int EW = 8;

    logic          clk;
    logic          clr_n;
    logic [CW-1:0] cnt_in;
    logic          wakeup_in;
    logic [CW-1:0] cmp_val;
    logic          cmp_en;
    logic          snap_req;
    logic          irq_ack;
    logic [CW-1:0] cnt_bin;
    logic [CW-1:0] cnt_snap;
    logic          snap_vld;
    logic          irq;
    logic [EW-1:0] evt_cnt;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    timer_event_ctrl #(.CW(CW), .GN(GN), .EW(EW)) dut (
        .clk(clk), .clr_n(clr_n), .cnt_in(cnt_in), .wakeup_in(wakeup_in),
        .cmp_val(cmp_val), .cmp_en(cmp_en), .snap_req(snap_req), .irq_ack(irq_ack),
        .cnt_bin(cnt_bin), .cnt_snap(cnt_snap), .snap_vld(snap_vld), .irq(irq),
        .evt_cnt(evt_cnt), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 irq raised, 2 waiting for ack release.
    logic [CW-1:0] m_bin, m_snap;
    bit            m_vld, m_irq, m_ovf, m_wk_prev, m_snap_prev, m_match_prev, m_pend;
    int            m_cnt, m_phase;

    typedef struct {
        logic [CW-1:0] raw;
        logic [CW-1:0] bin;
    } dec_vec_t;
    dec_vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] model_dec(input logic [CW-1:0] raw);
        logic [CW-1:0] r;
        int g;
        r = raw;
        for (int n = 0; n < GN; n++) begin
            g = int'(raw[4*n +: 4]);
            g = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
            r[4*n +: 4] = g[3:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_bin = '0; m_snap = '0; m_vld = 0; m_irq = 0; m_ovf = 0;
        m_wk_prev = 0; m_snap_prev = 0; m_match_prev = 0; m_pend = 0;
        m_cnt = 0; m_phase = 0;
    endtask

    task automatic model_tick();
        int inc, tot, maxv;
        bit match, wk, ce, ack_acc;
        maxv    = (1 << EW) - 1;
        match   = cmp_en && (m_bin == cmp_val);
        wk      = wakeup_in && !m_wk_prev;
        ce      = match && !m_match_prev;
        inc     = int'(wk) + int'(ce);
        ack_acc = (m_phase == 1) && irq_ack;
        if (snap_req && !m_snap_prev) begin
            m_snap = m_bin;
            m_vld  = 1;
        end else begin
            m_vld = 0;
        end
        if (ack_acc) begin
            m_cnt = inc;
            m_ovf = 0;
        end else begin
            tot = m_cnt + inc;
            if (tot > maxv) begin
                m_cnt = maxv;
                m_ovf = 1;
            end else begin
                m_cnt = tot;
            end
        end
        case (m_phase)
            0: if (inc != 0 || m_pend) begin m_phase = 1; m_pend = 0; end
            1: if (irq_ack) begin m_phase = 2; m_pend = (inc != 0); end
            default: begin
                if (inc != 0) m_pend = 1;
                if (!irq_ack) m_phase = 0;
            end
        endcase
        m_irq        = (m_phase == 1);
        m_wk_prev    = wakeup_in;
        m_snap_prev  = snap_req;
        m_match_prev = match;
        m_bin        = model_dec(cnt_in);
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        cnt_in = '0; wakeup_in = 1'b0; cmp_val = '0; cmp_en = 1'b0;
        snap_req = 1'b0; irq_ack = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr_n = 1'b1;
    endtask

    task automatic chk_model();
        chk("rnd_cnt_bin",  32'(cnt_bin),  32'(m_bin));
        chk("rnd_cnt_snap", 32'(cnt_snap), 32'(m_snap));
        chk("rnd_snap_vld", 32'(snap_vld), 32'(m_vld));
        chk("rnd_irq",      32'(irq),      32'(m_irq));
        chk("rnd_evt_cnt",  32'(evt_cnt),  32'(m_cnt));
        chk("rnd_ovf",      32'(ovf),      32'(m_ovf));
    endtask

    task automatic ack_cycle();
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; cyc();
    endtask

    initial begin
        tbl[0] = '{raw: 20'h013F7, bin: 20'h012A5};
        tbl[1] = '{raw: 20'h00008, bin: 20'h0000F};
        tbl[2] = '{raw: 20'hFFFFF, bin: 20'hFFAAA};
        tbl[3] = '{raw: 20'h55555, bin: 20'h55666};
        tbl[4] = '{raw: 20'hA9C21, bin: 20'hA9831};
        tbl[5] = '{raw: 20'h12267, bin: 20'h12345};
        tbl[6] = '{raw: 20'h00000, bin: 20'h00000};

        do_reset();
        chk("rst_cnt_bin",  32'(cnt_bin),  32'h0);
        chk("rst_cnt_snap", 32'(cnt_snap), 32'h0);
        chk("rst_snap_vld", 32'(snap_vld), 32'h0);
        chk("rst_irq",      32'(irq),      32'h0);
        chk("rst_evt_cnt",  32'(evt_cnt),  32'h0);
        chk("rst_ovf",      32'(ovf),      32'h0);

        for (int i = 0; i < 7; i++) begin
            cnt_in = tbl[i].raw;
            cyc();
            chk("decode", 32'(cnt_bin), 32'(tbl[i].bin));
        end

        // Alarm on entering equality, held count does not re-fire
        cnt_in = 20'h00008; cmp_val = 20'h00010; cmp_en = 1'b1;
        cyc(); cyc();
        chk("alarm_pre_evt", 32'(evt_cnt), 32'h0);
        cnt_in = 20'h00010;
        cyc();
        chk("alarm_bin", 32'(cnt_bin), 32'h10);
        chk("alarm_irq_early", 32'(irq), 32'h0);
        cyc();
        chk("alarm_irq", 32'(irq), 32'h1);
        chk("alarm_evt", 32'(evt_cnt), 32'h1);
        repeat (3) cyc();
        chk("alarm_hold_evt", 32'(evt_cnt), 32'h1);
        irq_ack = 1'b1; cyc();
        chk("alarm_ack_irq", 32'(irq), 32'h0);
        chk("alarm_ack_evt", 32'(evt_cnt), 32'h0);
        irq_ack = 1'b0; cyc(); cyc();
        chk("alarm_idle_irq", 32'(irq), 32'h0);
        cmp_en = 1'b0; cnt_in = 20'h00008;
        cyc(); cyc();
        cnt_in = 20'h00010;
        repeat (4) cyc();
        chk("alarm_dis_evt", 32'(evt_cnt), 32'h0);
        chk("alarm_dis_irq", 32'(irq), 32'h0);

        // Wakeup held high counts once
        wakeup_in = 1'b1; cyc();
        chk("wk_evt", 32'(evt_cnt), 32'h1);
        chk("wk_irq", 32'(irq), 32'h1);
        repeat (3) cyc();
        wakeup_in = 1'b0; cyc();
        chk("wk_hold_evt", 32'(evt_cnt), 32'h1);
        irq_ack = 1'b1; cyc();
        chk("wk_ack_irq", 32'(irq), 32'h0);
        chk("wk_ack_evt", 32'(evt_cnt), 32'h0);
        irq_ack = 1'b0; cyc(); cyc();
        chk("wk_idle_irq", 32'(irq), 32'h0);

        // Event during ACKW sets pending and re-raises irq after release
        wakeup_in = 1'b1; cyc();
        wakeup_in = 1'b0; cyc();
        chk("ackw_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1; cyc();
        chk("ackw_evt0", 32'(evt_cnt), 32'h0);
        wakeup_in = 1'b1; cyc();
        chk("ackw_evt1", 32'(evt_cnt), 32'h1);
        chk("ackw_irq_low", 32'(irq), 32'h0);
        wakeup_in = 1'b0; irq_ack = 1'b0; cyc();
        chk("ackw_idle_irq", 32'(irq), 32'h0);
        cyc();
        chk("ackw_reassert", 32'(irq), 32'h1);
        chk("ackw_evt_keep", 32'(evt_cnt), 32'h1);
        ack_cycle();
        chk("ackw_clear", 32'(evt_cnt), 32'h0);

        // Simultaneous wakeup and alarm (cmp_val/cmp_en change onto current count)
        cmp_en = 1'b1; wakeup_in = 1'b1; cyc();
        chk("both_evt", 32'(evt_cnt), 32'h2);
        chk("both_irq", 32'(irq), 32'h1);
        wakeup_in = 1'b0; cyc(); cyc();
        chk("both_hold", 32'(evt_cnt), 32'h2);
        cmp_en = 1'b0;
        ack_cycle();

        // Saturation
        for (int i = 0; i < 260; i++) begin
            wakeup_in = 1'b1; cyc();
            wakeup_in = 1'b0; cyc();
        end
        chk("sat_evt", 32'(evt_cnt), 32'hFF);
        chk("sat_ovf", 32'(ovf), 32'h1);
        irq_ack = 1'b1; cyc();
        chk("sat_ack_evt", 32'(evt_cnt), 32'h0);
        chk("sat_ack_ovf", 32'(ovf), 32'h0);
        irq_ack = 1'b0; cyc();

        // Snapshot with held request
        cnt_in = 20'h12267; cyc();
        chk("snap_bin", 32'(cnt_bin), 32'h12345);
        snap_req = 1'b1; cyc();
        chk("snap_val", 32'(cnt_snap), 32'h12345);
        chk("snap_vld1", 32'(snap_vld), 32'h1);
        cnt_in = 20'h00000; cyc();
        chk("snap_vld2", 32'(snap_vld), 32'h0);
        cyc();
        chk("snap_vld3", 32'(snap_vld), 32'h0);
        chk("snap_keep", 32'(cnt_snap), 32'h12345);
        snap_req = 1'b0; cyc();

        // Async reset while irq is high
        wakeup_in = 1'b1; cyc();
        wakeup_in = 1'b0;
        chk("rst_pre_irq", 32'(irq), 32'h1);
        #3;
        clr_n = 1'b0;
        #1;
        chk("rst_async_irq",  32'(irq),      32'h0);
        chk("rst_async_evt",  32'(evt_cnt),  32'h0);
        chk("rst_async_snap", 32'(cnt_snap), 32'h0);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)
                cnt_in = CW'($urandom);
            else if ($urandom_range(0, 1) == 0)
                cnt_in = CW'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0)
                cmp_val = CW'($urandom_range(0, 31));
            cmp_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0)
                wakeup_in = ~wakeup_in;
            snap_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                irq_ack = ~irq_ack;
            cyc();
            chk_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
